// File: rtl/sclk_burst_ctrl.sv
// Serial-clock burst generator: SETUP, then alternating HIGH/LOW phases of DIV/2 cycles, then TAIL.
// Define SCLK_CPOL_HIGH_EN for an sclk that idles high; the default build idles low.
module sclk_burst_ctrl #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic       inClk,
  input  logic       inResetN,
  input  logic       start,
  input  logic [4:0] bitCount,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       shiftEn,
  output logic       sampleEn
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here after a normal burst
  // SETUP | lead-in phase, first data bit presented
  // HIGH  | sclk at active level, data sampled on entry
  // LOW   | sclk at idle level, next data bit presented on entry
  // TAIL  | trailing idle phase after the last bit
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL} stateT;

`ifdef SCLK_CPOL_HIGH_EN
  localparam logic SCLK_IDLE = 1'b1;
`else
  localparam logic SCLK_IDLE = 1'b0;
`endif
  localparam logic SCLK_ACTIVE = ~SCLK_IDLE;
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(DIV / 2 - 1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] phaseCnt, phaseCntNext;
  logic [4:0]       remaining, remainingNext;
  logic             phaseEnd;
  logic             busyNext, doneNext, sclkNext, shiftEnNext, sampleEnNext;

  assign phaseEnd = (phaseCnt == PHASE_LAST);

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= SCLK_IDLE;
      shiftEn   <= 1'b0;
      sampleEn  <= 1'b0;
    end else begin
      state     <= stateNext;
      phaseCnt  <= phaseCntNext;
      remaining <= remainingNext;
      busy      <= busyNext;
      done      <= doneNext;
      sclk      <= sclkNext;
      shiftEn   <= shiftEnNext;
      sampleEn  <= sampleEnNext;
    end
  end

  always_comb begin
    stateNext     = state;
    phaseCntNext  = phaseEnd ? '0 : phaseCnt + CNT_W'(1);
    remainingNext = remaining;
    doneNext      = 1'b0;

    unique case (state)
      IDLE: begin
        phaseCntNext = '0;
        if (start && !abort && (bitCount != 5'd0)) begin
          stateNext     = SETUP;
          remainingNext = bitCount;
        end
      end
      SETUP: if (phaseEnd) stateNext = HIGH;
      HIGH: begin
        if (phaseEnd) begin
          remainingNext = remaining - 5'd1;
          stateNext     = (remaining == 5'd1) ? TAIL : LOW;
        end
      end
      LOW:  if (phaseEnd) stateNext = HIGH;
      TAIL: begin
        if (phaseEnd) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // abort overrides everything, including the done that TAIL would raise
    if (abort && (state != IDLE)) begin
      stateNext    = IDLE;
      phaseCntNext = '0;
      doneNext     = 1'b0;
    end

    // outputs are decoded from the next state so they land in the flops aligned with it
    busyNext     = (stateNext != IDLE);
    shiftEnNext  = (phaseCntNext == '0) && ((stateNext == SETUP) || (stateNext == LOW));
    sampleEnNext = (phaseCntNext == '0) && (stateNext == HIGH);
    sclkNext     = (stateNext == HIGH) ? SCLK_ACTIVE : SCLK_IDLE;
  end

endmodule

// File: tb/tb_sclk_burst_ctrl.sv
// Bench for sclk_burst_ctrl: DIV=4 and DIV=2 instances share stimulus and are compared each
// cycle against a timeline model derived from burst position arithmetic.
module tb_sclk_burst_ctrl;

`ifdef SCLK_CPOL_HIGH_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic ACT_LVL = ~IDLE_LVL;
  localparam logic [4:0] RST_VEC = {1'b0, 1'b0, IDLE_LVL, 1'b0, 1'b0};

  logic       inClk = 1'b0;
  logic       inResetN;
  logic       start;
  logic [4:0] bitCount;
  logic       abort;
  logic       busy4, done4, sclk4, shiftEn4, sampleEn4;
  logic       busy2, done2, sclk2, shiftEn2, sampleEn2;
  logic [9:0] obsAll, expAll;
  int         passCnt = 0;
  int         totalCnt = 0;
  int         cyc = 0;

  always #5 inClk = ~inClk;

  sclk_burst_ctrl #(.DIV(4), .CNT_W(16)) dut4 (
    .inClk(inClk), .inResetN(inResetN), .start(start), .bitCount(bitCount), .abort(abort),
    .busy(busy4), .done(done4), .sclk(sclk4), .shiftEn(shiftEn4), .sampleEn(sampleEn4));

  sclk_burst_ctrl #(.DIV(2), .CNT_W(16)) dut2 (
    .inClk(inClk), .inResetN(inResetN), .start(start), .bitCount(bitCount), .abort(abort),
    .busy(busy2), .done(done2), .sclk(sclk2), .shiftEn(shiftEn2), .sampleEn(sampleEn2));

  // vector order per instance: {busy, done, sclk, shiftEn, sampleEn}; slice 0 = DIV4, 1 = DIV2
  assign obsAll = {busy2, done2, sclk2, shiftEn2, sampleEn2, busy4, done4, sclk4, shiftEn4, sampleEn4};
  assign expAll = {gMdl[1].expVec, gMdl[0].expVec};

  // Model: a burst of n bits occupies busy cycles t = 1..(2n+1)H; phase p = (t-1)/H,
  // p = 0 lead-in, odd p = sclk active, even p < 2n = idle with new data, p = 2n tail.
  for (genvar g = 0; g < 2; g++) begin : gMdl
    localparam int H = (g == 0) ? 2 : 1;
    logic       active, doneF;
    int         t, n, p, pos;
    logic [4:0] expVec;

    always @(posedge inClk or negedge inResetN) begin
      if (!inResetN) begin
        active <= 1'b0;
        doneF  <= 1'b0;
        t      <= 0;
        n      <= 0;
      end else begin
        doneF <= 1'b0;
        if (active) begin
          if (abort) active <= 1'b0;
          else if (t == (2 * n + 1) * H) begin
            active <= 1'b0;
            doneF  <= 1'b1;
          end else t <= t + 1;
        end else if (start && !abort && (bitCount != 5'd0)) begin
          active <= 1'b1;
          t      <= 1;
          n      <= int'(bitCount);
        end
      end
    end

    always_comb begin
      p      = 0;
      pos    = 0;
      expVec = {1'b0, doneF, IDLE_LVL, 1'b0, 1'b0};
      if (active) begin
        p         = (t - 1) / H;
        pos       = (t - 1) % H;
        expVec[4] = 1'b1;
        expVec[3] = 1'b0;
        expVec[2] = (p % 2 == 1) ? ACT_LVL : IDLE_LVL;
        expVec[1] = (pos == 0) && (p % 2 == 0) && (p < 2 * n);
        expVec[0] = (pos == 0) && (p % 2 == 1);
      end
    end
  end

  task automatic tick();
    @(posedge inClk);
    @(negedge inClk);
    cyc++;
  endtask

  task automatic test_reset();
    inResetN = 1'b0;
    start    = 1'b1;
    bitCount = 5'd5;
    abort    = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      totalCnt++;
      if (obsAll[k*5 +: 5] !== RST_VEC)
        $display("FAIL reset_state div%0d: got %b expected %b", (k == 0) ? 4 : 2, obsAll[k*5 +: 5], RST_VEC);
      else passCnt++;
    end
    inResetN = 1'b1;
    bitCount = 5'd2;
    tick();
    start = 1'b0;
    totalCnt++;
    if ({busy4, busy2} !== 2'b11)
      $display("FAIL first_start_accept: got busy %b expected 11", {busy4, busy2});
    else passCnt++;
    repeat (14) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL reset_release div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
  endtask

  task automatic test_burst8();
    int busyN = 0, sampN = 0, shiftN = 0, doneN = 0, actN = 0;
    start    = 1'b1;
    bitCount = 5'd8;
    repeat (40) begin
      tick();
      start    = 1'b0;
      bitCount = 5'($urandom_range(0, 31));
      busyN  += int'(busy4);
      sampN  += int'(sampleEn4);
      shiftN += int'(shiftEn4);
      doneN  += int'(done4);
      actN   += int'(sclk4 == ACT_LVL);
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL burst8 div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
    totalCnt++;
    if ({busyN, sampN, shiftN, doneN, actN} !== {32'd34, 32'd8, 32'd8, 32'd1, 32'd16})
      $display("FAIL burst8_counts: got busy %0d sample %0d shift %0d done %0d active %0d expected 34 8 8 1 16",
               busyN, sampN, shiftN, doneN, actN);
    else passCnt++;
  endtask

  task automatic test_div2_single();
    logic [4:0] table1 [4];
    table1[0] = {1'b1, 1'b0, IDLE_LVL, 1'b1, 1'b0};
    table1[1] = {1'b1, 1'b0, ACT_LVL,  1'b0, 1'b1};
    table1[2] = {1'b1, 1'b0, IDLE_LVL, 1'b0, 1'b0};
    table1[3] = {1'b0, 1'b1, IDLE_LVL, 1'b0, 1'b0};
    start    = 1'b1;
    bitCount = 5'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      totalCnt++;
      if (obsAll[9:5] !== table1[i])
        $display("FAIL div2_single cycle %0d: got %b expected %b", i + 1, obsAll[9:5], table1[i]);
      else passCnt++;
    end
    repeat (6) begin
      tick();
      totalCnt++;
      if (obsAll[4:0] !== expAll[4:0])
        $display("FAIL div2_single_drain div4 cycle %0d: got %b expected %b", cyc, obsAll[4:0], expAll[4:0]);
      else passCnt++;
    end
  endtask

  task automatic test_abort();
    start    = 1'b1;
    bitCount = 5'd5;
    for (int i = 0; i < 7; i++) begin
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL abort_pre div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    totalCnt++;
    if (obsAll[4:0] !== RST_VEC)
      $display("FAIL abort_next div4: got %b expected %b", obsAll[4:0], RST_VEC);
    else passCnt++;
    repeat (20) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== RST_VEC)
          $display("FAIL abort_quiet div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], RST_VEC);
        else passCnt++;
      end
    end
    start    = 1'b1;
    abort    = 1'b1;
    bitCount = 5'd4;
    tick();
    start = 1'b0;
    abort = 1'b0;
    totalCnt++;
    if ({busy4, busy2} !== 2'b00)
      $display("FAIL abort_beats_start: got busy %b expected 00", {busy4, busy2});
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    int lastDone = -1;
    int doneN = 0;
    start    = 1'b1;
    bitCount = 5'd3;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (done4) begin
        if (lastDone >= 0) begin
          totalCnt++;
          if (i - lastDone != 15)
            $display("FAIL b2b_period: got %0d expected 15", i - lastDone);
          else passCnt++;
        end
        lastDone = i;
        doneN++;
      end
      totalCnt++;
      if (busy4 !== ~done4)
        $display("FAIL b2b_busy cycle %0d: got busy %b done %b expected busy = !done", i, busy4, done4);
      else passCnt++;
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL b2b div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
    totalCnt++;
    if (doneN != 4)
      $display("FAIL b2b_done_count: got %0d expected 4", doneN);
    else passCnt++;
    start = 1'b0;
    repeat (20) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL b2b_drain div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    start    = 1'b1;
    bitCount = 5'd6;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 inResetN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      totalCnt++;
      if (obsAll[k*5 +: 5] !== RST_VEC)
        $display("FAIL reset_async div%0d: got %b expected %b", (k == 0) ? 4 : 2, obsAll[k*5 +: 5], RST_VEC);
      else passCnt++;
    end
    #9 inResetN = 1'b1;
    @(negedge inClk);
    repeat (30) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== RST_VEC)
          $display("FAIL reset_discard div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], RST_VEC);
        else passCnt++;
      end
    end
    start    = 1'b1;
    bitCount = 5'd0;
    repeat (5) begin
      tick();
      totalCnt++;
      if ({busy4, done4, busy2, done2} !== 4'b0000)
        $display("FAIL zero_count cycle %0d: got busy/done %b expected 0000", cyc, {busy4, done4, busy2, done2});
      else passCnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    repeat (3000) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 40) == 0);
      bitCount = 5'($urandom_range(0, 31));
      tick();
      for (int k = 0; k < 2; k++) begin
        totalCnt++;
        if (obsAll[k*5 +: 5] !== expAll[k*5 +: 5])
          $display("FAIL random div%0d cycle %0d: got %b expected %b", (k == 0) ? 4 : 2, cyc, obsAll[k*5 +: 5], expAll[k*5 +: 5]);
        else passCnt++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    inResetN = 1'b0;
    start    = 1'b0;
    bitCount = 5'd0;
    abort    = 1'b0;
    @(negedge inClk);
    test_reset();
    test_burst8();
    test_div2_single();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
